config_chain_receiver: RTL and testbench
========================================

// Module: config_chain_receiver
// PURPOSE
// - Target-side end of the serial config shift-register link: receives ConfigClk/ConfigIn/ConfigLoad/Reset_not from the config writer, drives ConfigOut.
// - Instantiated in fabric as a chip emulator, looped back to the writer for bring-up and regression without silicon.
// - All link inputs are asynchronous to S_AXI_ACLK: oversampled, edge-detected, then acted on synchronously.
// PARAMETERS
// - CONFIG_REG_WIDTH  5164  shift-register / parallel-output length in bits (>=2)
// - SYNC_STAGES       2     synchronizer depth on every link input (>=2)
// - CNT_WIDTH         13    bit-counter width; must satisfy 2^CNT_WIDTH > CONFIG_REG_WIDTH
// PORTS
// - S_AXI_ACLK      in   1                  sampling clock (single clock domain)
// - S_AXI_ARESET    in   1                  asynchronous, active-high reset
// - ConfigClk       in   1                  link clock from writer (async)
// - ConfigIn        in   1                  serial data in (async)
// - ConfigLoad      in   1                  load strobe, rising edge commits (async)
// - Reset_not       in   1                  link reset, active low (async)
// - SuperpixSel     in   1                  variant select, passed through synchronized
// - ConfigOut       out  1                  serial data out = last shift stage
// - ParallelOut     out  CONFIG_REG_WIDTH   committed configuration
// - SuperpixSelOut  out  1                  synchronized SuperpixSel
// - BitCount        out  CNT_WIDTH          bits shifted since last load/link reset, saturating
// - LoadDone        out  1                  1-cycle pulse on commit
// - Overrun         out  1                  sticky: >CONFIG_REG_WIDTH bits shifted before a load
// - Underrun        out  1                  sticky: load with BitCount < CONFIG_REG_WIDTH
// BEHAVIOUR
// - Reset (S_AXI_ARESET=1): shift reg, ParallelOut, ConfigOut, BitCount, LoadDone, Overrun, Underrun, SuperpixSelOut all 0; synchronizer chains 0; state IDLE.
// - Inputs pass SYNC_STAGES flops, then one edge-detect flop; action occurs SYNC_STAGES+1 ACLK cycles after pin edge.
// - Link requirement: every ConfigClk/ConfigLoad level held >= SYNC_STAGES+2 ACLK cycles; shorter pulses undefined.
// - ConfigClk rise: sr <= {sr[W-2:0], ConfigIn_sync}; BitCount += 1, saturating at all-ones.
// - ConfigClk fall: ConfigOut <= sr[W-1] (output changes on falling edge only).
// - Overrun set when a shift occurs with BitCount == CONFIG_REG_WIDTH.
// - FSM: IDLE (BitCount==0) -> SHIFT on first rise; SHIFT -> COMMIT on ConfigLoad rise; COMMIT (1 cycle):
//   ParallelOut <= sr, LoadDone=1, Underrun set if BitCount<W, BitCount<=0 -> IDLE. sr is NOT cleared on commit.
// - ConfigLoad rise in IDLE: still commits (ParallelOut <= sr), Underrun set.
// - Simultaneous ConfigClk rise and ConfigLoad rise (same sync cycle): shift first, commit value includes new bit.
// - Reset_not_sync low: sr, BitCount, ConfigOut cleared, FSM -> IDLE, edges ignored; ParallelOut and sticky flags retained.
//   Sticky flags clear only on S_AXI_ARESET or on Reset_not rising edge.
// - S_AXI_ARESET mid-shift: immediate async clear of everything; first rise after release starts new frame.
// CONFIGURATION
// - CFG_RX_READBACK_EN defined: adds ports RdIdx in [clog2(ceil(W/32))], RdData out [32];
//   RdData registered 1 cycle after RdIdx = ParallelOut[32*RdIdx +: 32], zero-padded past W; RdIdx out of range -> 0; reset 0.
// - Not defined: ports absent, no read mux logic.
// TESTING (bench uses CONFIG_REG_WIDTH=8, ConfigClk half-period 10 ACLK)
// - Shift 8'hA5 MSB-first, pulse ConfigLoad -> ParallelOut=8'hA5, one LoadDone pulse, BitCount=0, no flags.
// - Shift 8'hA5 then 8'h3C, load -> ParallelOut=8'h3C; ConfigOut during second byte replays 1,0,1,0,0,1,0,1 on falls.
// - Shift 9 bits then load -> Overrun=1, ParallelOut = last 8 bits; 5 bits then load -> Underrun=1.
// - Reset_not low after 4 bits, release, shift 8'hFF, load -> ParallelOut=8'hFF, previous ParallelOut held during reset, flags cleared.
// - S_AXI_ARESET pulse mid-frame -> all outputs 0 within same cycle (async), recovery frame loads correctly.
// - Writer loopback (full width): writer frame readback via ConfigOut matches written bitstream bit-for-bit; CFG_RX_READBACK_EN: RdIdx=0 -> RdData=ParallelOut[31:0] one cycle later.

Source files
------------

// File: rtl/config_chain_receiver.sv
// Target-side receiver for the serial config shift-register link. All link pins are oversampled on S_AXI_ACLK.
// Optional word readback of the committed configuration is enabled by defining CFG_RX_READBACK_EN.
module config_chain_receiver #(
   parameter int CONFIG_REG_WIDTH = 5164,
   parameter int SYNC_STAGES      = 2,
   parameter int CNT_WIDTH        = 13
`ifdef CFG_RX_READBACK_EN
   ,
   localparam int NWORDS = (CONFIG_REG_WIDTH + 31) / 32,
   localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1
`endif
) (
   input  logic                        S_AXI_ACLK,
   input  logic                        S_AXI_ARESET,
   input  logic                        ConfigClk,
   input  logic                        ConfigIn,
   input  logic                        ConfigLoad,
   input  logic                        Reset_not,
   input  logic                        SuperpixSel,
   output logic                        ConfigOut,
   output logic [CONFIG_REG_WIDTH-1:0] ParallelOut,
   output logic                        SuperpixSelOut,
   output logic [CNT_WIDTH-1:0]        BitCount,
   output logic                        LoadDone,
   output logic                        Overrun,
   output logic                        Underrun
`ifdef CFG_RX_READBACK_EN
   ,
   input  logic [IDX_W-1:0]            RdIdx,
   output logic [31:0]                 RdData
`endif
);

   localparam logic [CNT_WIDTH-1:0] W_CNT = CNT_WIDTH'(CONFIG_REG_WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t state_q, state_d;

   // Bit order in each stage: {SuperpixSel, Reset_not, ConfigLoad, ConfigIn, ConfigClk}
   logic [SYNC_STAGES-1:0][4:0] sync_q;
   logic [4:0]                  pins_s;
   logic [2:0]                  prev_q;
   logic [CONFIG_REG_WIDTH-1:0] sr;

   logic clk_s, din_s, load_s, rn_s;
   logic clk_rise, clk_fall, load_rise, rn_rise;
   logic do_commit;

   assign pins_s = sync_q[SYNC_STAGES-1];
   assign clk_s  = pins_s[0];
   assign din_s  = pins_s[1];
   assign load_s = pins_s[2];
   assign rn_s   = pins_s[3];
   assign SuperpixSelOut = pins_s[4];

   assign clk_rise  =  clk_s  & ~prev_q[0];
   assign clk_fall  = ~clk_s  &  prev_q[0];
   assign load_rise =  load_s & ~prev_q[1];
   assign rn_rise   =  rn_s   & ~prev_q[2];

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], {SuperpixSel, Reset_not, ConfigLoad, ConfigIn, ConfigClk}};
         prev_q <= {rn_s, load_s, clk_s};
      end
   end

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) state_q <= IDLE;
      else              state_q <= state_d;
   end

   // A load edge commits from any state except COMMIT; a coincident shift lands first.
   always_comb begin
      state_d   = state_q;
      do_commit = 1'b0;
      if (!rn_s) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (load_rise)     state_d = COMMIT;
               else if (clk_rise) state_d = SHIFT;
            end
            SHIFT: begin
               if (load_rise) state_d = COMMIT;
            end
            COMMIT: begin
               do_commit = 1'b1;
               state_d   = clk_rise ? SHIFT : IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         sr          <= '0;
         ParallelOut <= '0;
         ConfigOut   <= 1'b0;
         BitCount    <= '0;
         LoadDone    <= 1'b0;
         Overrun     <= 1'b0;
         Underrun    <= 1'b0;
      end else begin
         LoadDone <= 1'b0;
         if (!rn_s) begin
            sr        <= '0;
            BitCount  <= '0;
            ConfigOut <= 1'b0;
         end else begin
            if (rn_rise) begin
               Overrun  <= 1'b0;
               Underrun <= 1'b0;
            end
            if (clk_rise) begin
               sr <= {sr[CONFIG_REG_WIDTH-2:0], din_s};
               if (BitCount == W_CNT) Overrun <= 1'b1;
            end
            if (clk_fall) ConfigOut <= sr[CONFIG_REG_WIDTH-1];
            if (do_commit) begin
               ParallelOut <= sr;
               LoadDone    <= 1'b1;
               if (BitCount < W_CNT) Underrun <= 1'b1;
               BitCount    <= clk_rise ? CNT_WIDTH'(1) : '0;
            end else if (clk_rise && (BitCount != '1)) begin
               BitCount <= BitCount + 1'b1;
            end
         end
      end
   end

`ifdef CFG_RX_READBACK_EN
   logic [NWORDS*32-1:0] padded;

   always_comb begin
      padded = '0;
      padded[CONFIG_REG_WIDTH-1:0] = ParallelOut;
   end

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET)                RdData <= '0;
      else if (int'(RdIdx) < NWORDS)   RdData <= padded[32*int'(RdIdx) +: 32];
      else                             RdData <= '0;
   end
`endif

endmodule

// File: tb/tb_config_chain_receiver.sv
// Bench for config_chain_receiver at width 8: bit-serial writer driver, ConfigOut and
// ParallelOut scoreboards against a bench-side bit history model.
module tb_config_chain_receiver;

   localparam int W  = 8;
   localparam int SS = 2;
   localparam int CW = 13;

   logic          aclk = 1'b0;
   logic          areset, cclk, cin, cload, rn, sps;
   logic          config_out, superpix_out, load_done, overrun, underrun;
   logic [W-1:0]  parallel_out;
   logic [CW-1:0] bit_count;
`ifdef CFG_RX_READBACK_EN
   logic          rd_idx;
   logic [31:0]   rd_data;
`endif

   config_chain_receiver #(
      .CONFIG_REG_WIDTH(W), .SYNC_STAGES(SS), .CNT_WIDTH(CW)
   ) dut (
      .S_AXI_ACLK(aclk), .S_AXI_ARESET(areset), .ConfigClk(cclk), .ConfigIn(cin),
      .ConfigLoad(cload), .Reset_not(rn), .SuperpixSel(sps), .ConfigOut(config_out),
      .ParallelOut(parallel_out), .SuperpixSelOut(superpix_out), .BitCount(bit_count),
      .LoadDone(load_done), .Overrun(overrun), .Underrun(underrun)
`ifdef CFG_RX_READBACK_EN
      , .RdIdx(rd_idx), .RdData(rd_data)
`endif
   );

   always #5 aclk = ~aclk;

   int           errors = 0;
   int           checks = 0;
   logic         exp_q[$];
   logic [W-1:0] par_q[$];
   logic         hist[$];
   int           m_cnt;
   logic         m_over, m_under;
   logic [W-1:0] m_par;

   task automatic wait_clk(input int n);
      repeat (n) @(posedge aclk);
   endtask

   // Shift register contents are the last W bits written since reset, zero-filled.
   function automatic logic [W-1:0] model_sr();
      logic [W-1:0] v = '0;
      for (int i = 0; i < W; i++)
         if (hist.size() - 1 - i >= 0) v[i] = hist[hist.size() - 1 - i];
      return v;
   endfunction

   task automatic model_shift(input logic b);
      if (m_cnt == W) m_over = 1'b1;
      m_cnt++;
      hist.push_back(b);
   endtask

   task automatic send_bit(input logic b);
      logic e;
      cin = b;
      wait_clk(10);
      cclk = 1'b1;
      model_shift(b);
      exp_q.push_back(hist.size() >= W ? hist[hist.size() - W] : 1'b0);
      wait_clk(10);
      cclk = 1'b0;
      wait_clk(6);
      @(negedge aclk);
      e = exp_q.pop_front();
      checks++;
      if (config_out !== e) begin
         errors++;
         $display("FAIL config_out_on_fall: got %b expected %b (bit %0d)", config_out, e, hist.size());
      end
      wait_clk(3);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   // Load strobe; with_rise raises ConfigClk in the same cycle to exercise the coincident case.
   task automatic do_load(input bit with_rise, input logic b);
      int           pulses;
      logic [W-1:0] got, e;
      pulses = 0;
      got    = '0;
      if (with_rise) begin
         cin = b;
         wait_clk(10);
         cclk = 1'b1;
         model_shift(b);
      end
      if (m_cnt < W) m_under = 1'b1;
      m_cnt = 0;
      m_par = model_sr();
      par_q.push_back(m_par);
      cload = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge aclk);
         if (load_done) begin
            pulses++;
            got = parallel_out;
         end
      end
      cload = 1'b0;
      cclk  = 1'b0;
      e = par_q.pop_front();
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL load_done_pulses: got %0d expected 1", pulses);
      end
      checks++;
      if (pulses == 0 || got !== e) begin
         errors++;
         $display("FAIL parallel_out_commit: got %h expected %h", got, e);
      end
      wait_clk(10);
   endtask

   task automatic test_reset();
      areset = 1'b1; cclk = 1'b0; cin = 1'b0; cload = 1'b0; rn = 1'b1; sps = 1'b1;
      m_cnt = 0; m_over = 1'b0; m_under = 1'b0; m_par = '0;
      wait_clk(4);
      @(negedge aclk);
      checks++;
      if ({parallel_out, config_out, bit_count, load_done, overrun, underrun, superpix_out} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: po=%h co=%b bc=%0d ld=%b ov=%b un=%b sp=%b expected all zero",
                  parallel_out, config_out, bit_count, load_done, overrun, underrun, superpix_out);
      end
      sps = 1'b0;
      #3 areset = 1'b0;
      wait_clk(10);
   endtask

   task automatic test_flags(input string name);
      @(negedge aclk);
      checks++;
      if (overrun !== m_over || underrun !== m_under || bit_count !== CW'(m_cnt)) begin
         errors++;
         $display("FAIL %s_flags: ov=%b un=%b bc=%0d expected ov=%b un=%b bc=%0d",
                  name, overrun, underrun, bit_count, m_over, m_under, m_cnt);
      end
   endtask

   task automatic test_basic();
      send_byte(8'hA5);
      test_flags("basic_pre_load");
      do_load(0, 1'b0);
      test_flags("basic");
      checks++;
      if (parallel_out !== 8'hA5) begin
         errors++;
         $display("FAIL basic_parallel: got %h expected a5", parallel_out);
      end
   endtask

   task automatic test_overrun_underrun();
      for (int i = 0; i < 9; i++) send_bit(1'($urandom_range(0, 1)));
      test_flags("overrun_pre_load");
      do_load(0, 1'b0);
      test_flags("overrun");
      for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
      do_load(0, 1'b0);
      test_flags("underrun");
   endtask

   task automatic test_back_to_back();
      send_byte(8'hA5);
      send_byte(8'h3C);
      do_load(0, 1'b0);
      test_flags("back_to_back");
      checks++;
      if (parallel_out !== 8'h3C) begin
         errors++;
         $display("FAIL back_to_back_parallel: got %h expected 3c", parallel_out);
      end
   endtask

   task automatic test_link_reset();
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rn = 1'b0;
      wait_clk(10);
      cclk = 1'b1;
      wait_clk(10);
      cclk = 1'b0;
      wait_clk(10);
      @(negedge aclk);
      checks++;
      if (parallel_out !== m_par || bit_count !== '0 || config_out !== 1'b0 ||
          overrun !== m_over || underrun !== m_under) begin
         errors++;
         $display("FAIL link_reset_hold: po=%h bc=%0d co=%b ov=%b un=%b expected po=%h bc=0 co=0 ov=%b un=%b",
                  parallel_out, bit_count, config_out, overrun, underrun, m_par, m_over, m_under);
      end
      hist.delete();
      m_cnt = 0;
      rn = 1'b1;
      m_over = 1'b0;
      m_under = 1'b0;
      wait_clk(10);
      test_flags("link_release");
      send_byte(8'hFF);
      do_load(0, 1'b0);
      test_flags("link_reset_frame");
   endtask

   task automatic test_simultaneous();
      send_byte(8'h00);
      for (int i = 0; i < 7; i++) send_bit(1'(i % 2));
      do_load(0, 1'b0);
      for (int i = 0; i < 7; i++) send_bit(1'(i % 2));
      do_load(1, 1'b1);
      test_flags("simultaneous");
      do_load(0, 1'b0);
      test_flags("idle_load");
   endtask

   task automatic test_async_reset();
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      #3 areset = 1'b1;
      #1;
      checks++;
      if ({parallel_out, config_out, bit_count, load_done, overrun, underrun} !== '0) begin
         errors++;
         $display("FAIL async_reset: po=%h co=%b bc=%0d ld=%b ov=%b un=%b expected all zero",
                  parallel_out, config_out, bit_count, load_done, overrun, underrun);
      end
      hist.delete();
      m_cnt = 0; m_over = 1'b0; m_under = 1'b0; m_par = '0;
      #22 areset = 1'b0;
      wait_clk(10);
      send_byte(8'hA5);
      do_load(0, 1'b0);
      test_flags("async_recovery");
   endtask

   task automatic test_superpix();
      for (int v = 1; v >= 0; v--) begin
         sps = 1'(v);
         wait_clk(5);
         @(negedge aclk);
         checks++;
         if (superpix_out !== 1'(v)) begin
            errors++;
            $display("FAIL superpix_sync: got %b expected %b", superpix_out, 1'(v));
         end
      end
   endtask

   task automatic test_loopback();
      for (int i = 0; i < 2 * W; i++) send_bit(1'($urandom_range(0, 1)));
      do_load(0, 1'b0);
      test_flags("loopback");
`ifdef CFG_RX_READBACK_EN
      rd_idx = 1'b0;
      wait_clk(2);
      @(negedge aclk);
      checks++;
      if (rd_data !== 32'(m_par)) begin
         errors++;
         $display("FAIL readback_word0: got %h expected %h", rd_data, 32'(m_par));
      end
`endif
   endtask

   initial begin
`ifdef CFG_RX_READBACK_EN
      rd_idx = 1'b0;
`endif
      test_reset();
      test_basic();
      test_overrun_underrun();
      test_back_to_back();
      test_link_reset();
      test_simultaneous();
      test_superpix();
      test_async_reset();
      test_loopback();
      checks++;
      if (exp_q.size() != 0 || par_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d/%0d entries left expected 0", exp_q.size(), par_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
